// File: rtl/aes128_key_schedule_pkg.sv
// Shared AES constants: forward S-box table, round constants and the GF(2^8) xtime helper.
package aes_pkg;

  // FIPS-197 forward S-box; entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [3:0] LAST_ROUND = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_key_schedule_if.sv
// Key-load request and round-key words exchanged between the cipher and its key schedule.
interface aes128_key_schedule_if;
  logic         kld;
  logic [127:0] key;
  logic [31:0]  wo_0;
  logic [31:0]  wo_1;
  logic [31:0]  wo_2;
  logic [31:0]  wo_3;
  logic [3:0]   round;

  modport master (output kld, key, input wo_0, wo_1, wo_2, wo_3, round);
  modport slave  (input kld, key, output wo_0, wo_1, wo_2, wo_3, round);
endinterface

// File: rtl/aes128_key_schedule_sbox.sv
// Combinational AES forward S-box, shared by the key schedule and the cipher state path.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);
  // Entry a lives at byte (255 - a) == ~a of the packed table.
  assign d = SBOX_TBL[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes128_key_schedule.sv
// AES-128 round-key generator: loads key as round 0, then one FIPS-197 expansion step per clock up to round 10.
module aes128_key_schedule
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  aes128_key_schedule_if.slave   ks
);

  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic [3:0]  round_q, round_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] rot_w, sub_w, t_w;
  logic        expand;

  assign rot_w = {w3_q[23:0], w3_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_w[8*i +: 8]),
      .d (sub_w[8*i +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon_q, 24'h0};

  // Rcon is 00 only after reset and never during a loaded schedule, so it doubles as the "key loaded" flag.
  assign expand = (rcon_q != 8'h00) && (round_q < LAST_ROUND);

  always_comb begin
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    if (expand) begin
      w0_d    = w0_q ^ t_w;
      w1_d    = w1_q ^ w0_d;
      w2_d    = w2_q ^ w1_d;
      w3_d    = w3_q ^ w2_d;
      round_d = round_q + 4'd1;
      if (round_q < 4'd9) begin
        rcon_d = RCON[round_q + 4'd1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
      rcon_q  <= '0;
    end else if (ks.kld) begin
      w0_q    <= ks.key[127:96];
      w1_q    <= ks.key[95:64];
      w2_q    <= ks.key[63:32];
      w3_q    <= ks.key[31:0];
      round_q <= '0;
      rcon_q  <= RCON[0];
    end else begin
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  assign ks.wo_0  = w0_q;
  assign ks.wo_1  = w1_q;
  assign ks.wo_2  = w2_q;
  assign ks.wo_3  = w3_q;
  assign ks.round = round_q;

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Directed self-checking bench for aes128_key_schedule and the aes_sbox it uses.
module tb_aes128_key_schedule;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes128_key_schedule_if ks_if ();

  aes128_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks_if)
  );

  logic [7:0] sb_a;
  logic [7:0] sb_d;
  aes_sbox u_sbox_tb (
    .a (sb_a),
    .d (sb_d)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_rk [11];
  logic [127:0] rk;

  assign rk = {ks_if.wo_0, ks_if.wo_1, ks_if.wo_2, ks_if.wo_3};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    ks_if.kld = 1'b1;
    ks_if.key = k;
    step();
    ks_if.kld = 1'b0;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = x;
    logic [7:0] bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic test_sbox();
    logic [7:0] spot_in  [4];
    logic [7:0] spot_out [4];
    spot_in  = '{8'h00, 8'h01, 8'h53, 8'hff};
    spot_out = '{8'h63, 8'h7c, 8'hed, 8'h16};
    for (int i = 0; i < 4; i++) begin
      sb_a = spot_in[i];
      #1;
      checks++;
      if (sb_d !== spot_out[i]) begin
        errors++;
        $display("FAIL sbox_spot in=%h got %h expected %h", spot_in[i], sb_d, spot_out[i]);
      end
    end
    for (int i = 0; i < 256; i++) begin
      sb_a = 8'(i);
      #1;
      checks++;
      if (sb_d !== sbox_model(8'(i))) begin
        errors++;
        $display("FAIL sbox_all in=%h got %h expected %h", i[7:0], sb_d, sbox_model(8'(i)));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rk !== '0 || ks_if.round !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %h round %0d expected zero round 0", c, rk, ks_if.round);
      end
      step();
    end
  endtask

  task automatic test_fips();
    load(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      checks++;
      if (rk !== fips_rk[r] || ks_if.round !== 4'(r)) begin
        errors++;
        $display("FAIL fips_round got %h round %0d expected %h round %0d", rk, ks_if.round, fips_rk[r], r);
      end
      if (r < 10) step();
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (rk !== fips_rk[10] || ks_if.round !== 4'd10) begin
        errors++;
        $display("FAIL fips_hold got %h round %0d expected %h round 10", rk, ks_if.round, fips_rk[10]);
      end
    end
  endtask

  task automatic test_zero_key();
    load('0);
    checks++;
    if (rk !== '0 || ks_if.round !== 4'd0) begin
      errors++;
      $display("FAIL zero_r0 got %h round %0d expected zero round 0", rk, ks_if.round);
    end
    step();
    checks++;
    if (rk !== 128'h62636363626363636263636362636363 || ks_if.round !== 4'd1) begin
      errors++;
      $display("FAIL zero_r1 got %h round %0d expected 62636363x4 round 1", rk, ks_if.round);
    end
    step();
    checks++;
    if (rk !== 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa || ks_if.round !== 4'd2) begin
      errors++;
      $display("FAIL zero_r2 got %h round %0d expected 9b9898c9f9fbfbaa9b9898c9f9fbfbaa round 2", rk, ks_if.round);
    end
  endtask

  task automatic test_reload();
    load('0);
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (ks_if.round !== 4'd4) begin
      errors++;
      $display("FAIL reload_pre got round %0d expected 4", ks_if.round);
    end
    load(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      checks++;
      if (rk !== fips_rk[r] || ks_if.round !== 4'(r)) begin
        errors++;
        $display("FAIL reload_round got %h round %0d expected %h round %0d", rk, ks_if.round, fips_rk[r], r);
      end
      if (r < 10) step();
    end
  endtask

  task automatic test_back_to_back();
    load('0);
    load(FIPS_KEY);
    checks++;
    if (rk !== fips_rk[0] || ks_if.round !== 4'd0) begin
      errors++;
      $display("FAIL b2b_r0 got %h round %0d expected %h round 0", rk, ks_if.round, fips_rk[0]);
    end
    step();
    checks++;
    if (rk !== fips_rk[1] || ks_if.round !== 4'd1) begin
      errors++;
      $display("FAIL b2b_r1 got %h round %0d expected %h round 1", rk, ks_if.round, fips_rk[1]);
    end
  endtask

  task automatic test_reset_priority();
    load(FIPS_KEY);
    step();
    rst = 1'b1;
    ks_if.kld = 1'b1;
    ks_if.key = FIPS_KEY;
    step();
    rst = 1'b0;
    ks_if.kld = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (rk !== '0 || ks_if.round !== 4'd0) begin
        errors++;
        $display("FAIL rst_prio cycle %0d got %h round %0d expected zero round 0", c, rk, ks_if.round);
      end
      step();
    end
    load(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      if (r == 0 || r == 1 || r == 10) begin
        checks++;
        if (rk !== fips_rk[r] || ks_if.round !== 4'(r)) begin
          errors++;
          $display("FAIL rst_prio_reload got %h round %0d expected %h round %0d", rk, ks_if.round, fips_rk[r], r);
        end
      end
      if (r < 10) step();
    end
  endtask

  task automatic test_reset_mid();
    load(FIPS_KEY);
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (rk !== fips_rk[6] || ks_if.round !== 4'd6) begin
      errors++;
      $display("FAIL rst_mid_pre got %h round %0d expected %h round 6", rk, ks_if.round, fips_rk[6]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rk !== '0 || ks_if.round !== 4'd0) begin
        errors++;
        $display("FAIL rst_mid cycle %0d got %h round %0d expected zero round 0", c, rk, ks_if.round);
      end
      step();
    end
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    ks_if.kld = 1'b0;
    ks_if.key = '0;
    sb_a      = 8'h00;

    test_reset();
    test_sbox();
    test_fips();
    test_zero_key();
    test_reload();
    test_back_to_back();
    test_reset_priority();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
